// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx -- 8N1 UART receiver with selectable baud rate and a valid/ready
// output register.
//
// Ports
//   clk         system clock, all logic on the rising edge
//   rst         synchronous active-high reset
//   rx_line     asynchronous serial input (idle high, LSB first)
//   mode[3:0]   baud select: 0=4800, 1=9600, 2=115200, 3=256000, else 9600
//   data_out    received byte, stable while data_valid is high
//   data_valid  data_out holds an unconsumed byte
//   data_ready  consumer accepts data_out when data_valid & data_ready
//   frame_err   one-cycle pulse when the stop bit is sampled low
//   overrun     one-cycle pulse when a finished byte is dropped because the
//               output register is still occupied
// ---------------------------------------------------------------------------
module uart_rx #(
    parameter int unsigned CLK_FREQ = 100000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_line,
    input  logic [3:0] mode,
    output logic [7:0] data_out,
    output logic       data_valid,
    input  logic       data_ready,
    output logic       frame_err,
    output logic       overrun
);

    // Bit period in clocks: ceil(CLK_FREQ / baud) + 1
    localparam int unsigned P_4800   = (CLK_FREQ + 4800   - 1) / 4800   + 1;
    localparam int unsigned P_9600   = (CLK_FREQ + 9600   - 1) / 9600   + 1;
    localparam int unsigned P_115200 = (CLK_FREQ + 115200 - 1) / 115200 + 1;
    localparam int unsigned P_256000 = (CLK_FREQ + 256000 - 1) / 256000 + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    state_t      state_reg, state_next;
    logic        armed_reg, armed_next;
    logic [31:0] cnt_reg, cnt_next;
    logic [2:0]  bit_idx_reg, bit_idx_next;
    logic [7:0]  shift_reg, shift_next;
    logic [3:0]  mode_reg, mode_next;
    logic [1:0]  sync_reg;
    logic        rxs;

    logic        deliver_reg;
    logic [7:0]  data_out_reg;
    logic        data_valid_reg;
    logic        frame_err_reg;
    logic        overrun_reg;

    logic [31:0] last_cnt;
    logic [31:0] half_cnt;

    logic        stop_good;
    logic        stop_bad;
    logic        accept;
    logic        load;
    logic        drop;

    assign rxs = sync_reg[1];

    // Timing always follows the mode captured at start-bit detection, so a
    // mode change in the middle of a frame cannot disturb it.
    always_comb begin
        case (mode_reg)
            4'd0:    last_cnt = P_4800 - 1;
            4'd1:    last_cnt = P_9600 - 1;
            4'd2:    last_cnt = P_115200 - 1;
            4'd3:    last_cnt = P_256000 - 1;
            default: last_cnt = P_9600 - 1;
        endcase
        half_cnt = (last_cnt + 32'd1) >> 1;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_reg       <= 2'b11;
            state_reg      <= ST_IDLE;
            armed_reg      <= 1'b0;
            cnt_reg        <= 32'd0;
            bit_idx_reg    <= 3'd0;
            shift_reg      <= 8'h00;
            mode_reg       <= 4'd0;
            deliver_reg    <= 1'b0;
            data_out_reg   <= 8'h00;
            data_valid_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
            overrun_reg    <= 1'b0;
        end else begin
            sync_reg      <= {sync_reg[0], rx_line};
            state_reg     <= state_next;
            armed_reg     <= armed_next;
            cnt_reg       <= cnt_next;
            bit_idx_reg   <= bit_idx_next;
            shift_reg     <= shift_next;
            mode_reg      <= mode_next;
            // The stop sample is staged through deliver_reg so the byte
            // lands in the output register one cycle after that edge.
            deliver_reg   <= stop_good;
            frame_err_reg <= stop_bad;
            overrun_reg   <= drop;
            if (load) begin
                data_out_reg   <= shift_reg;
                data_valid_reg <= 1'b1;
            end else if (accept) begin
                data_valid_reg <= 1'b0;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_next   = state_reg;
        armed_next   = armed_reg;
        cnt_next     = cnt_reg;
        bit_idx_next = bit_idx_reg;
        shift_next   = shift_reg;
        mode_next    = mode_reg;
        case (state_reg)
            ST_IDLE: begin
                // A start is only recognised after the line has been seen
                // high; this blocks re-triggering on a held break.
                if (rxs) begin
                    armed_next = 1'b1;
                end else if (armed_reg) begin
                    state_next = ST_START;
                    cnt_next   = 32'd0;
                    mode_next  = mode;
                end
            end
            ST_START: begin
                if (cnt_reg == half_cnt) begin
                    if (!rxs) begin
                        state_next   = ST_DATA;
                        cnt_next     = 32'd0;
                        bit_idx_next = 3'd0;
                    end else begin
                        state_next = ST_IDLE;   // glitch, not a real start
                    end
                end else begin
                    cnt_next = cnt_reg + 32'd1;
                end
            end
            ST_DATA: begin
                if (cnt_reg == last_cnt) begin
                    shift_next[bit_idx_reg] = rxs;
                    cnt_next                = 32'd0;
                    if (bit_idx_reg == 3'd7) begin
                        state_next = ST_STOP;
                    end else begin
                        bit_idx_next = bit_idx_reg + 3'd1;
                    end
                end else begin
                    cnt_next = cnt_reg + 32'd1;
                end
            end
            ST_STOP: begin
                if (cnt_reg == last_cnt) begin
                    cnt_next   = 32'd0;
                    state_next = ST_IDLE;
                    if (!rxs) begin
                        armed_next = 1'b0;
                    end
                end else begin
                    cnt_next = cnt_reg + 32'd1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        stop_good = (state_reg == ST_STOP) && (cnt_reg == last_cnt) && rxs;
        stop_bad  = (state_reg == ST_STOP) && (cnt_reg == last_cnt) && !rxs;
        accept    = data_valid_reg && data_ready;
        load      = deliver_reg && (!data_valid_reg || data_ready);
        drop      = deliver_reg && data_valid_reg && !data_ready;
    end

    assign data_out   = data_out_reg;
    assign data_valid = data_valid_reg;
    assign frame_err  = frame_err_reg;
    assign overrun    = overrun_reg;

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx -- directed self-checking bench for uart_rx.
// The DUT runs at CLK_FREQ = 10 MHz so the slow 9600-baud frame stays short:
//   mode 2 (115200): L = ceil(86.81)   = 87,   P = 88,   H = 44
//   mode 3 (256000): L = ceil(39.06)   = 40,   P = 41,   H = 20
//   mode 7 (9600)  : L = ceil(1041.67) = 1042, P = 1043, H = 521
// Start-bit drive to data_valid high: 2 sync flops + 1 detect edge +
// (H+1) edges in START + 9 bit periods + 1 delivery edge = 5 + H + 9P.
// The glitch is shortened to 10 cycles so it remains well below H.
// ---------------------------------------------------------------------------
module tb_uart_rx;

    localparam int CLK_HZ = 10000000;
    localparam int P_M2   = 88;
    localparam int H_M2   = 44;
    localparam int P_M3   = 41;
    localparam int H_M3   = 20;
    localparam int P_M7   = 1043;
    localparam int H_M7   = 521;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_line;
    logic [3:0] mode;
    logic [7:0] data_out;
    logic       data_valid;
    logic       data_ready;
    logic       frame_err;
    logic       overrun;

    int n_checks = 0;
    int n_fail   = 0;

    // monitor state (written only by the monitor process)
    int         cyc         = 0;
    int         dv_rises    = 0;
    int         dv_cycles   = 0;
    int         fe_cycles   = 0;
    int         ov_cycles   = 0;
    int         dv_rise_cyc = 0;
    logic [7:0] dv_byte     = 8'h00;
    logic       dv_prev     = 1'b0;

    // snapshots (written only by the stimulus process)
    int s_rises, s_cycles, s_fe, s_ov;

    uart_rx #(.CLK_FREQ(CLK_HZ)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .rx_line    (rx_line),
        .mode       (mode),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .frame_err  (frame_err),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (data_valid) begin
            dv_cycles <= dv_cycles + 1;
            if (!dv_prev) begin
                dv_rises    <= dv_rises + 1;
                dv_rise_cyc <= cyc;
                dv_byte     <= data_out;
            end
        end
        dv_prev <= data_valid;
        if (frame_err) fe_cycles <= fe_cycles + 1;
        if (overrun)   ov_cycles <= ov_cycles + 1;
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic snap();
        s_rises  = dv_rises;
        s_cycles = dv_cycles;
        s_fe     = fe_cycles;
        s_ov     = ov_cycles;
    endtask

    task automatic send_byte(input logic [7:0] b, input int p, input logic stop_val,
                             output int t_start);
        @(negedge clk);
        rx_line = 1'b0;
        t_start = cyc;
        repeat (p) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_line = b[i];
            repeat (p) @(negedge clk);
        end
        rx_line = stop_val;
        repeat (p) @(negedge clk);
        rx_line = 1'b1;
    endtask

    initial begin
        int t0;
        rst        = 1'b1;
        rx_line    = 1'b1;
        mode       = 4'd2;
        data_ready = 1'b1;
        idle(4);
        check_eq("rst_data_out",   int'(data_out),   8'h00);
        check_eq("rst_data_valid", int'(data_valid), 0);
        check_eq("rst_frame_err",  int'(frame_err),  0);
        check_eq("rst_overrun",    int'(overrun),    0);
        rst = 1'b0;
        idle(10);

        // Plain frame, consumer always ready
        snap();
        send_byte(8'hA5, P_M2, 1'b1, t0);
        idle(10);
        check_eq("a5_rises",   dv_rises - s_rises, 1);
        check_eq("a5_byte",    int'(dv_byte), 8'hA5);
        check_eq("a5_width",   dv_cycles - s_cycles, 1);
        check_eq("a5_latency", dv_rise_cyc - t0, 5 + H_M2 + 9 * P_M2);
        check_eq("a5_fe",      fe_cycles - s_fe, 0);
        check_eq("a5_ov",      ov_cycles - s_ov, 0);
        check_eq("a5_hold",    int'(data_out), 8'hA5);

        // Framing error, then recovery
        snap();
        send_byte(8'h3C, P_M2, 1'b0, t0);
        idle(2 * P_M2);
        check_eq("3c_fe_pulse", fe_cycles - s_fe, 1);
        check_eq("3c_no_dv",    dv_rises - s_rises, 0);
        snap();
        send_byte(8'h55, P_M2, 1'b1, t0);
        idle(10);
        check_eq("55_rises", dv_rises - s_rises, 1);
        check_eq("55_byte",  int'(dv_byte), 8'h55);
        check_eq("55_fe",    fe_cycles - s_fe, 0);

        // Short low glitch is rejected
        snap();
        @(negedge clk);
        rx_line = 1'b0;
        idle(10);
        rx_line = 1'b1;
        idle(2 * P_M2);
        check_eq("glitch_no_dv", dv_rises - s_rises, 0);
        check_eq("glitch_no_fe", fe_cycles - s_fe, 0);
        snap();
        send_byte(8'h0F, P_M2, 1'b1, t0);
        idle(10);
        check_eq("0f_rises", dv_rises - s_rises, 1);
        check_eq("0f_byte",  int'(dv_byte), 8'h0F);

        // Overrun while the consumer stalls
        data_ready = 1'b0;
        snap();
        send_byte(8'h11, P_M2, 1'b1, t0);
        idle(10);
        check_eq("11_rises", dv_rises - s_rises, 1);
        check_eq("11_byte",  int'(data_out), 8'h11);
        send_byte(8'h22, P_M2, 1'b1, t0);
        idle(10);
        check_eq("22_ov_pulse",  ov_cycles - s_ov, 1);
        check_eq("22_no_rise",   dv_rises - s_rises, 1);
        check_eq("22_keep_byte", int'(data_out), 8'h11);
        check_eq("22_valid",     int'(data_valid), 1);
        data_ready = 1'b1;
        @(negedge clk);
        check_eq("accept_valid", int'(data_valid), 0);
        check_eq("accept_byte",  int'(data_out), 8'h11);

        // Reset pulse during data bit 4 of 0xFF
        snap();
        fork
            send_byte(8'hFF, P_M2, 1'b1, t0);
            begin
                @(negedge clk);
                idle(5 * P_M2 + P_M2 / 2);
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                check_eq("midrst_data_out",   int'(data_out),   8'h00);
                check_eq("midrst_data_valid", int'(data_valid), 0);
                check_eq("midrst_frame_err",  int'(frame_err),  0);
                check_eq("midrst_overrun",    int'(overrun),    0);
            end
        join
        idle(2 * P_M2);
        check_eq("midrst_no_dv", dv_rises - s_rises, 0);
        check_eq("midrst_no_fe", fe_cycles - s_fe, 0);
        snap();
        send_byte(8'h80, P_M2, 1'b1, t0);
        idle(10);
        check_eq("80_rises", dv_rises - s_rises, 1);
        check_eq("80_byte",  int'(dv_byte), 8'h80);

        // 256000 baud
        mode = 4'd3;
        snap();
        send_byte(8'h5A, P_M3, 1'b1, t0);
        idle(10);
        check_eq("5a_byte",    int'(dv_byte), 8'h5A);
        check_eq("5a_latency", dv_rise_cyc - t0, 5 + H_M3 + 9 * P_M3);

        // Out-of-range mode falls back to 9600; mode change mid-frame ignored
        mode = 4'd7;
        snap();
        fork
            send_byte(8'hC3, P_M7, 1'b1, t0);
            begin
                idle(3 * P_M7);
                mode = 4'd2;
            end
        join
        idle(10);
        check_eq("c3_rises",   dv_rises - s_rises, 1);
        check_eq("c3_byte",    int'(dv_byte), 8'hC3);
        check_eq("c3_latency", dv_rise_cyc - t0, 5 + H_M7 + 9 * P_M7);
        check_eq("c3_fe",      fe_cycles - s_fe, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
